// File: rtl/core_pkg.sv
// Core-wide constants shared by the fetch, decode and execute stages.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with a registered head; flushed by execute redirects.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = core_pkg::XLEN,
  parameter int ILEN  = core_pkg::ILEN,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [ILEN-1:0]            inst_i,
  output logic                       valid_ro,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            pc_ro,
  output logic [ILEN-1:0]            inst_ro,
  input  logic                       jump_taken_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       afull_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][XLEN-1:0] pc_mem;
  logic [DEPTH-1:0][ILEN-1:0] inst_mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              cnt;
  logic                       push, pop;

  // Handshake flags come from registered state only, so ready_o never depends on ready_i.
  assign ready_o  = (cnt != CW'(DEPTH));
  assign valid_ro = (cnt != '0);
  assign count_o  = cnt;
  assign afull_o  = (cnt >= CW'(AFULL));
  assign pc_ro    = pc_mem[rd_ptr];
  assign inst_ro  = inst_mem[rd_ptr];

  assign push = valid_i  & ready_o & ~jump_taken_i;
  assign pop  = valid_ro & ready_i & ~jump_taken_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mem   <= '0;
      inst_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else if (jump_taken_i) begin
      // storage is left as-is; only the bookkeeping is cleared
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc_i;
        inst_mem[wr_ptr] <= inst_i;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule
